// File: rtl/vga_timing_out_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_out_if : pixel input plus raster counters and DAC/sync outputs
// Revision 1.0
// ---------------------------------------------------------------------------
interface vga_timing_out_if;
   logic [7:0]  RGBIn;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        startOfFrame;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        hSync;
   logic        vSync;
   logic        blankN;

   modport master (
      input  RGBIn,
      output pixelX, pixelY, startOfFrame, red, green, blue, hSync, vSync, blankN
   );

   modport slave (
      output RGBIn,
      input  pixelX, pixelY, startOfFrame, red, green, blue, hSync, vSync, blankN
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_out.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_out : raster counters, pipeline-aligned sync/blank, RGB332 -> 24-bit DAC
// Revision 1.0   (VGA_TEST_PATTERN_EN: replace RGBIn with 8 vertical colour bars)
// ---------------------------------------------------------------------------
module vga_timing_out #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic             clk,
   input  logic             resetN,
   vga_timing_out_if.master vga
);
   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam int          LAST     = PIPE_DELAY - 1;

   logic [10:0]           h_count;
   logic [10:0]           v_count;
   logic                  active;
   logic                  hs;
   logic                  vs;
   logic [PIPE_DELAY-1:0] active_d;
   logic [PIPE_DELAY-1:0] hs_d;
   logic [PIPE_DELAY-1:0] vs_d;
   logic [7:0]            pixel;
   logic [7:0]            red_q;
   logic [7:0]            green_q;
   logic [7:0]            blue_q;
   logic                  hsync_n_q;
   logic                  vsync_n_q;
   logic                  blank_n_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? 11'd0 : v_count + 11'd1;
      end else begin
         h_count <= h_count + 11'd1;
      end
   end

   always_comb begin
      active = (h_count < H_VIS) && (v_count < V_VIS);
      hs     = (h_count >= HS_START) && (h_count <= HS_END);
      vs     = (v_count >= VS_START) && (v_count <= VS_END);
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
   logic [10:0] h_d [PIPE_DELAY];
   logic [10:0] bar_full;
   logic        unused_rgb;

   // Counter travels with the decode bits so bar edges line up with blankN.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < PIPE_DELAY; i++) h_d[i] <= '0;
      end else begin
         h_d[0] <= h_count;
         for (int i = 1; i < PIPE_DELAY; i++) h_d[i] <= h_d[i-1];
      end
   end

   always_comb begin
      bar_full = h_d[LAST] / BAR_W;
      pixel    = {{3{bar_full[2]}}, {3{bar_full[1]}}, {2{bar_full[0]}}};
   end

   assign unused_rgb = &{1'b0, vga.RGBIn, bar_full[10:3]};
`else
   assign pixel = vga.RGBIn;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         active_d <= '0;
         hs_d     <= '0;
         vs_d     <= '0;
      end else begin
         active_d[0] <= active;
         hs_d[0]     <= hs;
         vs_d[0]     <= vs;
         for (int i = 1; i < PIPE_DELAY; i++) begin
            active_d[i] <= active_d[i-1];
            hs_d[i]     <= hs_d[i-1];
            vs_d[i]     <= vs_d[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         blank_n_q <= 1'b0;
      end else begin
         hsync_n_q <= ~hs_d[LAST];
         vsync_n_q <= ~vs_d[LAST];
         blank_n_q <= active_d[LAST];
         if (active_d[LAST]) begin
            red_q   <= {pixel[7:5], pixel[7:5], pixel[7:6]};
            green_q <= {pixel[4:2], pixel[4:2], pixel[4:3]};
            blue_q  <= {4{pixel[1:0]}};
         end else begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
         end
      end
   end

   assign vga.pixelX       = h_count;
   assign vga.pixelY       = v_count;
   assign vga.startOfFrame = (h_count == 11'd0) && (v_count == V_VIS);
   assign vga.red          = red_q;
   assign vga.green        = green_q;
   assign vga.blue         = blue_q;
   assign vga.hSync        = hsync_n_q;
   assign vga.vSync        = vsync_n_q;
   assign vga.blankN       = blank_n_q;
endmodule
`default_nettype wire

// File: doc/vga_timing_out.md
# vga_timing_out

Display back end of the VGA pipeline. It generates the raster counters (pixelX/pixelY) that all object drawers consume, and emits a start-of-frame strobe for game logic. It takes the registered 8-bit RRRGGGBB pixel from the object priority mux and drives the 24-bit DAC outputs plus hSync, vSync and blankN. Sync and blank are delayed so they stay aligned with the pixel that comes back through the drawer/mux pipeline.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, clocks from pixelX/pixelY change to matching RGBIn (≥1)

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset, asynchronous, active-low
- RGBIn  in  8  pixel from object mux, {R[2:0],G[2:0],B[1:0]}
- pixelX  out  11  current horizontal counter (0..H_TOTAL-1)
- pixelY  out  11  current vertical counter (0..V_TOTAL-1)
- startOfFrame  out  1  one-clock pulse when entering vertical blanking
- red, green, blue  out  8 each  DAC colour
- hSync, vSync  out  1  sync, active-low
- blankN  out  1  high during visible pixel

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hCount increments every clock; at H_TOTAL-1 it wraps to 0 and vCount increments. vCount wraps to 0 at V_TOTAL-1 together with the hCount wrap.
- pixelX = hCount, pixelY = vCount, both registered.
- Stage-0 decode from the counters:
  - active = hCount<H_ACTIVE && vCount<V_ACTIVE
  - hs = hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- active, hs and vs pass through a PIPE_DELAY-deep shift register, then an output register sampled together with RGBIn.
- Colour expansion by bit replication:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
- When the delayed active bit is 0, red, green and blue are 0 regardless of RGBIn.
- startOfFrame = 1 for exactly one clock when hCount==0 && vCount==V_ACTIVE. It is not delayed.

## Timing
- Reset values:
  - hCount = vCount = 0; pixelX = pixelY = 0
  - delay line active/hs/vs = 0
  - red = green = blue = 0; hSync = vSync = 1; blankN = 0; startOfFrame = 0
- First clock after reset release: pixelX = 1. Counters never stall.
- hSync, vSync, blankN and the RGB outputs change PIPE_DELAY+1 clocks after the corresponding pixelX/pixelY value.
- RGBIn is sampled PIPE_DELAY clocks after its pixelX. The output register adds one clock.
- Line period is exactly H_TOTAL clocks. Frame period is exactly H_TOTAL×V_TOTAL clocks (420000 at defaults).
- hSync low for H_SYNC clocks per line, on every line including vertical blanking.
- vSync low for V_SYNC×H_TOTAL clocks. Its edges coincide with hCount (delayed) == 0.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). After release the raster restarts at (0,0); no partial-frame recovery.

## Configuration
- VGA_TEST_PATTERN_EN defined: RGBIn is ignored. The pixel is replaced by 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar index i = delayed hCount/(H_ACTIVE/8).
  - Colour = {i[2]?3'b111:0, i[1]?3'b111:0, i[0]?2'b11:0}, so bar 0 is black and bar 7 is white.
  - The bar index is computed from the counter at the same delay stage, so bar edges align exactly with blankN.
- Undefined: normal RGBIn path. Ports are identical in both builds.

## Test plan
- Reset held 10 clocks, released → red/green/blue = 0, hSync = vSync = 1, blankN = 0; pixelX counts 0..799 then wraps to 0 while pixelY goes 0→1.
- Free run one line → hSync low for exactly 96 clocks, falling edge 656+PIPE_DELAY+1 clocks after pixelX = 0; blankN high for exactly 640 clocks per visible line.
- Free run two frames → startOfFrame pulses exactly once per 420000 clocks, at pixelY = 480, pixelX = 0; vSync low for 1600 clocks starting when the delayed vCount = 490.
- Drive RGBIn = 8'hE0 during active, 8'hFF during blank → output FF/00/00 while blankN = 1 and 00/00/00 while blankN = 0; with PIPE_DELAY = 2, the first red pixel appears 3 clocks after pixelX = 0.
- Drive RGBIn = 8'b101_010_01 → red = 8'hB6, green = 8'h49, blue = 8'h55.
- Assert resetN at pixelX = 300, pixelY = 200 for 3 clocks → outputs return to reset values at once; the next frame starts at (0,0). With VGA_TEST_PATTERN_EN, pixel 80 of a visible line outputs 00/00/FF and pixel 639 outputs FF/FF/FF.
